// File: rtl/seq_chunk_adder_if.sv
// Start/done bus of the sequential chunk adder. The master issues operations
// and the adder (slave) returns busy/done and the registered result.
//
// Handshake: the slave samples start on a rising clock edge and accepts it
// only when it is not busy (idle, or in the done cycle for back-to-back use).
// a/b/cin/sub are captured on that edge. start seen while busy is ignored.
// done is a one-cycle pulse; s/cout/ovf are valid from then until the next
// accepted start.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock,
// LSB chunk first, carry held in a register between chunks.
module seq_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_chunk_adder_if.slave  bus,
  output logic [1:0]        state_dbg
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N          = WIDTH / CHUNK_SAFE;
  localparam int KW         = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  // Debug encoding: IDLE=0, RUN=1, DONE=2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] sum_c;
  logic             c_out;

  assign accept = bus.start && (state != RUN);
  assign last   = (k == KW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: both flags come straight from the state register.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  assign state_dbg = state;

  // The single CHUNK-bit adder slice.
  always_comb begin
    a_c            = CHUNK'(a_q >> (int'(k) * CHUNK));
    b_c            = CHUNK'(b_q >> (int'(k) * CHUNK));
    {c_out, sum_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
  end

  // Subtraction is a + ~b + 1, so b is inverted and the carry forced to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k       <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub ? 1'b1 : bus.cin;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k       <= '0;
    end else if (state == RUN) begin
      s_q[int'(k) * CHUNK +: CHUNK] <= sum_c;
      carry_q                       <= c_out;
      k                             <= k + 1'b1;
      if (last) begin
        cout_q <= c_out;
        // Carry into the MSB is recovered from the MSB sum bit.
        ovf_q  <= a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1] ^ c_out;
      end
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three configurations (64/8, 64/64, 16/1) checked
// every cycle against an arithmetic model, plus hand-computed directed vectors.
module tb_seq_chunk_adder;

  localparam int NCFG = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [NCFG];
  logic        sub_v   [NCFG];
  logic        cin_v   [NCFG];
  logic [63:0] a_v     [NCFG];
  logic [63:0] b_v     [NCFG];
  logic        busy_v  [NCFG];
  logic        done_v  [NCFG];
  logic        cout_v  [NCFG];
  logic        ovf_v   [NCFG];
  logic [63:0] s_v     [NCFG];
  logic [1:0]  dbg_v   [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = (g == 2) ? 16 : 64;
    localparam int C = (g == 0) ? 8 : ((g == 1) ? 64 : 1);

    seq_chunk_adder_if #(.WIDTH(W)) bus ();

    assign bus.start = start_v[g];
    assign bus.sub   = sub_v[g];
    assign bus.cin   = cin_v[g];
    assign bus.a     = a_v[g][W-1:0];
    assign bus.b     = b_v[g][W-1:0];
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.cout;
    assign ovf_v[g]  = bus.ovf;
    assign s_v[g]    = 64'(bus.s);

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (dbg_v[g])
    );
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int cfg_w(input int c);
    return (c == 2) ? 16 : 64;
  endfunction

  function automatic int cfg_n(input int c);
    return (c == 0) ? 8 : ((c == 1) ? 1 : 16);
  endfunction

  // Reference arithmetic: returns {ovf, cout, s} for a w-bit operation.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                         input logic cin, input logic sub);
    logic [63:0] msk, a, b, s;
    logic [64:0] full;
    logic        co, ov;
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a   = a_in & msk;
    b   = b_in & msk;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + 65'(cin);
      s    = full[63:0] & msk;
      co   = full[w];
      ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    end else begin
      s    = (a - b) & msk;
      co   = (a >= b);
      ov   = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
    end
    return {ov, co, s};
  endfunction

  // ---------------- model: timing by countdown, results by arithmetic ----------------
  logic [65:0] exp_q [NCFG][$];
  int          m_cnt [NCFG] = '{default: 0};
  bit          m_done[NCFG] = '{default: 1'b0};
  logic [65:0] held  [NCFG] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < NCFG; c++) begin
      if (!rst_n) begin
        m_cnt[c]  = 0;
        m_done[c] = 1'b0;
        held[c]   = '0;
        exp_q[c].delete();
      end else if (start_v[c] && m_cnt[c] == 0) begin
        exp_q[c].push_back(ref_op(cfg_w(c), a_v[c], b_v[c], cin_v[c], sub_v[c]));
        m_cnt[c]  = cfg_n(c);
        m_done[c] = 1'b0;
      end else if (m_cnt[c] > 0) begin
        m_cnt[c]--;
        if (m_cnt[c] == 0) begin
          m_done[c] = 1'b1;
          held[c]   = exp_q[c].pop_front();
        end
      end else begin
        m_done[c] = 1'b0;
      end
    end
  end

  // ---------------- compare, every cycle, away from the active edge ----------------
  always @(negedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d busy", c), busy_v[c], (m_cnt[c] > 0));
      check($sformatf("cfg%0d done", c), done_v[c], m_done[c]);
      if (m_cnt[c] == 0)
        check($sformatf("cfg%0d result", c), {ovf_v[c], cout_v[c], s_v[c]}, held[c]);
      else
        check($sformatf("cfg%0d flags in run", c), {ovf_v[c], cout_v[c]}, 2'b00);
    end
  end

  // ---------------- driver tasks (called positioned at a falling edge) ----------------
  task automatic run_op(input int c, input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input int pulse_at,
                        output logic [65:0] res, output int lat, output int busy_n);
    bit got;
    got    = 1'b0;
    lat    = 0;
    busy_n = 0;
    res    = '0;
    a_v[c] = a; b_v[c] = b; cin_v[c] = cin; sub_v[c] = sub; start_v[c] = 1'b1;
    while (!got && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      // Scrambled operands after acceptance must not matter.
      start_v[c] = (lat == pulse_at);
      a_v[c]     = {$urandom, $urandom};
      b_v[c]     = {$urandom, $urandom};
      cin_v[c]   = 1'($urandom);
      sub_v[c]   = 1'($urandom);
      if (busy_v[c]) busy_n++;
      if (done_v[c]) begin
        got = 1'b1;
        res = {ovf_v[c], cout_v[c], s_v[c]};
      end
    end
    check($sformatf("cfg%0d done within bound", c), got, 1'b1);
  endtask

  task automatic do_op(input int c, input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input int pulse_at, input logic [65:0] exp_res,
                       input int exp_lat, input string tag);
    logic [65:0] res;
    int          lat, busy_n;
    run_op(c, a, b, cin, sub, pulse_at, res, lat, busy_n);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_n, exp_lat - 1);
  endtask

  task automatic random_ops(input int c, input int count);
    logic [63:0] a, b;
    logic        cin, sub;
    for (int i = 0; i < count; i++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
      sub = 1'($urandom);
      do_op(c, a, b, cin, sub, 0, ref_op(cfg_w(c), a, b, cin, sub), cfg_n(c) + 1,
            $sformatf("cfg%0d random %0d", c, i));
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int c = 0; c < NCFG; c++) begin
      start_v[c] = 1'b0; sub_v[c] = 1'b0; cin_v[c] = 1'b0; a_v[c] = '0; b_v[c] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset busy", busy_v[0], 1'b0);
    check("reset done", done_v[0], 1'b0);
    check("reset s", s_v[0], 64'h0);
    check("reset cout/ovf", {cout_v[0], ovf_v[0]}, 2'b00);
    check("reset state idle", dbg_v[0], 2'd0);
    rst_n = 1'b1;

    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, {1'b0, 1'b1, 64'h0}, 9, "wraparound");
    @(negedge clk);
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0,
          {1'b1, 1'b0, 64'h8000_0000_0000_0000}, 9, "ovf pos");
    @(negedge clk);
    do_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0,
          {1'b1, 1'b1, 64'h0}, 9, "ovf neg");
    @(negedge clk);
    do_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 0, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 9, "sub 5-7");
    @(negedge clk);
    do_op(0, 64'd7, 64'd5, 1'b0, 1'b1, 0, {1'b0, 1'b1, 64'd2}, 9, "sub 7-5");
    @(negedge clk);
    do_op(0, 64'd7, 64'd5, 1'b1, 1'b1, 0, {1'b0, 1'b1, 64'd2}, 9, "sub ignores cin");
    @(negedge clk);
    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0,
          {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF}, 9, "sub ovf");
    @(negedge clk);
    do_op(0, 64'd1, 64'd2, 1'b1, 1'b0, 0, {1'b0, 1'b0, 64'd4}, 9, "add cin");
    @(negedge clk);
    do_op(0, 64'h1234, 64'h1111, 1'b0, 1'b0, 3, {1'b0, 1'b0, 64'h2345}, 9, "start mid run");
    // The next two start in the done cycle of the previous operation.
    do_op(0, 64'd10, 64'd20, 1'b0, 1'b0, 0, {1'b0, 1'b0, 64'd30}, 9, "back to back 1");
    do_op(0, 64'd100, 64'd1, 1'b0, 1'b1, 0, {1'b0, 1'b1, 64'd99}, 9, "back to back 2");

    // Reset after three chunks have been written.
    @(negedge clk);
    a_v[0] = 64'h1111_1111_1111_1111; b_v[0] = 64'h1111_1111_1111_1111;
    cin_v[0] = 1'b0; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("partial s", s_v[0], 64'h0000_0000_0022_2222);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy_v[0], 1'b0);
    check("abort done", done_v[0], 1'b0);
    check("abort s", s_v[0], 64'h0);
    check("abort cout/ovf", {cout_v[0], ovf_v[0]}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 64'd3, 64'd4, 1'b1, 1'b0, 0, {1'b0, 1'b0, 64'd8}, 9, "after reset");
    @(negedge clk);

    random_ops(0, 100);
    @(negedge clk);
    do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, {1'b0, 1'b1, 64'h0}, 2, "cfg1 wraparound");
    @(negedge clk);
    do_op(2, 64'h7FFF, 64'h1, 1'b0, 1'b0, 0, {1'b1, 1'b0, 64'h8000}, 17, "cfg2 ovf");
    @(negedge clk);
    random_ops(1, 1000);
    @(negedge clk);
    random_ops(2, 1000);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
